uart_sha256_interface: RTL and testbench
========================================

Name: uart_sha256_interface

Overview:
Byte-stream front end and single-block SHA-256 engine. It sits behind a UART receiver and accepts bytes of one pre-padded 512-bit message block. After 64 bytes it runs the SHA-256 compression function from the standard IV and presents the 256-bit digest with a valid flag. Padding and length encoding are the host's responsibility.

Parameters:
None. Block size fixed at 64 bytes; round count fixed at 64.

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst  input  1  synchronous reset, active-low; sampled on rising clk
data_in  input  8  received byte, valid when data_ready=1
data_ready  input  1  byte strobe; one byte accepted per clk cycle it is high while collecting
sha_digest  output  256  digest H0..H7; H0 in [255:224], H7 in [31:0]
digest_valid  output  1  high while sha_digest holds a completed result

Behaviour:
- Reset (rst=0 at an edge):
  - state=COLLECT, byte count=0, block buffer=0, working regs=0.
  - sha_digest=0, digest_valid=0.
  - Reset overrides all activity, including mid-collection and mid-hash.
- States: COLLECT, INIT, ROUND, FINAL.
- COLLECT:
  - Each edge with data_ready=1 stores data_in and increments the count.
  - Byte k (0-based, arrival order) goes to block bits [511-8k -: 8]; the first byte is the MSB of W0.
  - Accepting the first byte of a block clears digest_valid; sha_digest keeps its old value until overwritten.
  - Accepting byte 63 moves to INIT and wraps the count to 0.
- INIT (1 cycle): load a..h from IV 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19. Load the 16-word schedule window W0..W15 from the block. Set round=0.
- ROUND (64 cycles, one round per cycle, t=0..63):
  - Wt = window word for t<16; otherwise s1(Wt-2)+Wt-7+s0(Wt-15)+Wt-16.
  - Implemented as a 16-word shift window.
  - T1 = h+S1(e)+Ch(e,f,g)+Kt+Wt; T2 = S0(a)+Maj(a,b,c).
  - Standard register rotate: a=T1+T2, e=d+T1.
  - All additions are mod 2^32.
  - After t=63 go to FINAL.
- FINAL (1 cycle): sha_digest = {IV0+a, …, IV7+h}, each addition mod 2^32; digest_valid<=1; return to COLLECT.
- Latency: if the edge accepting byte 63 is edge N, digest_valid and sha_digest are valid after edge N+66.
- data_ready during INIT, ROUND or FINAL is ignored; those bytes are dropped and not counted.
- Every block is hashed from the IV with no chaining between blocks. Multi-block messages are out of scope.
- digest_valid is a level. It stays high indefinitely until the next block's first byte is accepted or reset is applied.
- data_in is don't-care when data_ready=0.

Decomposition:
- Shared package sha256_pkg:
  - 64-entry K constant array and 8 IV constants.
  - Functions: ch, maj, big_sigma0/1, small_sigma0/1, implemented as rotate-right helpers.
  - State enum typedef.
- One natural sub-module: sha256_core. Inputs: start, 512-bit block. Outputs: done, 256-bit digest. It holds INIT/ROUND/FINAL.
- The top module keeps only the byte collector and the valid/clear logic.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> sha_digest=0, digest_valid=0. Pulse data_ready with rst=0 -> nothing stored.
- "abc": send bytes 61 62 63 80, 59×00, then 18, each a 1-cycle data_ready pulse with a 1-cycle gap -> sha_digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad. digest_valid rises exactly 66 edges after the last byte is accepted.
- Empty message: 80, 62×00, 00 -> sha_digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Ignore-while-busy: repeat "abc" while toggling data_ready with random bytes during the 66 hash cycles -> digest still ba7816bf…15ad. The next block starts counting from byte 0.
- Back-to-back: "abc" block, then empty block -> digest_valid drops on the first byte of the second block. The second digest is e3b0c442…b855, independent of the first.
- Reset mid-operation: apply rst=0 after 30 bytes, and separately during ROUND -> outputs return to 0. A subsequent full "abc" block yields ba7816bf…15ad.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and the shared state type.
package sha256_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    INIT    = 2'd1,
    ROUND   = 2'd2,
    FINAL   = 2'd3
  } sha_state_e;

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_core.sv
// Single-block SHA-256 compression, one round per cycle, always from the IV.
// state   | meaning
// COLLECT | idle, waiting for start
// INIT    | load a..h from IV and schedule window from block
// ROUND   | one compression round per cycle, t = round_q
// FINAL   | digest (IV + working regs) presented with done
module sha256_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  sha_state_e  state_q, state_d;
  logic [31:0] work_q [8];
  logic [31:0] work_d [8];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [5:0]  round_q, round_d;
  logic [31:0] t1, t2, w_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= COLLECT;
      work_q  <= '{default: '0};
      w_q     <= '{default: '0};
      round_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      w_q     <= w_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    w_d     = w_q;
    round_d = round_q;
    t1 = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
         + K[round_q] + w_q[0];
    t2 = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
    // w_q[0] is always W_t; the word appended at the tail is W_(t+16)
    w_next = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

    unique case (state_q)
      COLLECT: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        for (int i = 0; i < 8; i++) work_d[i] = IV[i];
        for (int i = 0; i < 16; i++) w_d[i] = block[511 - 32*i -: 32];
        round_d = '0;
        state_d = ROUND;
      end
      ROUND: begin
        work_d[0] = t1 + t2;
        work_d[1] = work_q[0];
        work_d[2] = work_q[1];
        work_d[3] = work_q[2];
        work_d[4] = work_q[3] + t1;
        work_d[5] = work_q[4];
        work_d[6] = work_q[5];
        work_d[7] = work_q[6];
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_next;
        round_d = round_q + 6'd1;
        if (round_q == 6'd63) state_d = FINAL;
      end
      FINAL: begin
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    digest = '0;
    for (int i = 0; i < 8; i++) digest[255 - 32*i -: 32] = IV[i] + work_q[i];
  end

  assign busy = (state_q != COLLECT);
  assign done = (state_q == FINAL);

endmodule

// File: rtl/uart_sha256_interface.sv
// Byte collector in front of sha256_core; holds the digest and its valid level.
module uart_sha256_interface
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   data_in,
  input  logic         data_ready,
  output logic [255:0] sha_digest,
  output logic         digest_valid
);

  logic [5:0]   count_q, count_d;
  logic [511:0] block_q, block_d;
  logic [255:0] digest_q, digest_d;
  logic         valid_q, valid_d;
  logic         accept, start;
  logic         core_busy, core_done;
  logic [255:0] core_digest;

  sha256_core u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .block  (block_q),
    .busy   (core_busy),
    .done   (core_done),
    .digest (core_digest)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= '0;
      block_q  <= '0;
      digest_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      block_q  <= block_d;
      digest_q <= digest_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    count_d  = count_q;
    block_d  = block_q;
    digest_d = digest_q;
    valid_d  = valid_q;
    // bytes arriving while the core is busy are dropped
    accept   = data_ready && !core_busy;
    start    = accept && (count_q == 6'd63);
    if (accept) begin
      // byte k lands at bit offset 8*(63-k), so the first byte is the MSB of W0
      block_d[{~count_q, 3'b000} +: 8] = data_in;
      count_d = count_q + 6'd1;
      if (count_q == 6'd0) valid_d = 1'b0;
    end
    if (core_done) begin
      digest_d = core_digest;
      valid_d  = 1'b1;
    end
  end

  assign sha_digest   = digest_q;
  assign digest_valid = valid_q;

endmodule

// File: tb/tb_uart_sha256_interface.sv
// Randomized byte-stream bench with an independent SHA-256 reference model.
module tb_uart_sha256_interface;

  logic         clk;
  logic         rst;
  logic [7:0]   data_in;
  logic         data_ready;
  logic [255:0] sha_digest;
  logic         digest_valid;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [31:0] HIV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  uart_sha256_interface dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_ready   (data_ready),
    .sha_digest   (sha_digest),
    .digest_valid (digest_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [255:0] model_sha(input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2, chv, mjv;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = HIV[i];
    for (int t = 0; t < 64; t++) begin
      chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
      mjv = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + chv + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + mjv;
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = HIV[i] + v[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send_bytes(input logic [511:0] blk, input int n, input bit rand_gap);
    logic [255:0] prev;
    prev = sha_digest;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      data_ready = 1'b1;
      data_in    = blk[511 - 8*k -: 8];
      @(negedge clk);
      data_ready = 1'b0;
      if (k == 0) begin
        check("valid_clear_first_byte", {255'b0, digest_valid}, 256'd0);
        check("digest_hold_first_byte", sha_digest, prev);
      end
      if (rand_gap && k != n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic wait_digest(input bit noise, output int edges);
    edges = 0;
    if (noise) begin
      data_ready = 1'($urandom_range(0, 1));
      data_in    = 8'($urandom);
    end
    while (edges < 200) begin
      @(negedge clk);
      edges++;
      if (digest_valid) break;
      if (noise) begin
        data_ready = 1'($urandom_range(0, 1));
        data_in    = 8'($urandom);
      end
    end
    data_ready = 1'b0;
  endtask

  task automatic run_block(input string tag, input logic [511:0] blk, input logic [255:0] exp,
                           input bit rand_gap, input bit noise);
    int edges;
    send_bytes(blk, 64, rand_gap);
    wait_digest(noise, edges);
    check({tag, "_latency"}, 256'(edges), 256'd66);
    check({tag, "_digest"}, sha_digest, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [511:0] blk;
    rst        = 1'b0;
    data_ready = 1'b0;
    data_in    = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_digest", sha_digest, 256'd0);
    check("reset_valid", {255'b0, digest_valid}, 256'd0);
    data_ready = 1'b1;
    data_in    = 8'h61;
    @(negedge clk);
    data_ready = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    check("no_store_in_reset", {255'b0, digest_valid}, 256'd0);

    run_block("abc", ABC_BLK, ABC_DIG, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("valid_level_holds", {255'b0, digest_valid}, 256'd1);

    run_block("empty_b2b", EMPTY_BLK, EMPTY_DIG, 1'b0, 1'b0);
    run_block("abc_noise", ABC_BLK, ABC_DIG, 1'b0, 1'b1);
    run_block("empty_after_noise", EMPTY_BLK, EMPTY_DIG, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
      run_block($sformatf("rand%0d", r), blk, model_sha(blk), 1'b1, r[0]);
    end

    send_bytes(ABC_BLK, 30, 1'b0);
    pulse_reset();
    check("rst_collect_digest", sha_digest, 256'd0);
    check("rst_collect_valid", {255'b0, digest_valid}, 256'd0);
    run_block("abc_after_rst_collect", ABC_BLK, ABC_DIG, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
    send_bytes(blk, 64, 1'b0);
    repeat (20) @(negedge clk);
    pulse_reset();
    check("rst_round_digest", sha_digest, 256'd0);
    check("rst_round_valid", {255'b0, digest_valid}, 256'd0);
    repeat (80) @(negedge clk);
    check("rst_round_no_late_valid", {255'b0, digest_valid}, 256'd0);
    run_block("abc_after_rst_round", ABC_BLK, ABC_DIG, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
